// File: rtl/mainfsm_if.sv
// Control bundle between the multicycle sequencer and the datapath/FPU.
// The sequencer drives the master side; the datapath sits on the slave side.
interface mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FpuDone;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       FpuW;
  logic       Branch;
  logic       FpuStart;
  logic       FpuErr;

  modport master (
    input  Op, Funct, FpuDone,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, FpuW, Branch, FpuStart, FpuErr
  );

  modport slave (
    output Op, Funct, FpuDone,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, FpuW, Branch, FpuStart, FpuErr
  );
endinterface

// File: rtl/mainfsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback plus an
// FPU issue/wait/writeback path with a bounded wait and abort.
module mainfsm #(
  parameter int FPU_TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  mainfsm_if.master bus
);

  localparam int CW = $clog2(FPU_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(FPU_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
    ALUWB, BRANCH, FPUISSUE, FPUWAIT, FPUWB, FPUABORT
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt, wait_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // The abort compare fires before the counter can reach its ceiling, so it never wraps.
  always_comb begin
    next_state    = FETCH;
    wait_cnt_next = wait_cnt;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FPUISSUE;
        endcase
      end
      MEMADR:   next_state = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      FPUISSUE: begin
        wait_cnt_next = '0;
        next_state    = FPUWAIT;
      end
      FPUWAIT: begin
        wait_cnt_next = wait_cnt + CW'(1);
        if (bus.FpuDone)
          next_state = FPUWB;
        else if (wait_cnt == LAST_WAIT)
          next_state = FPUABORT;
        else
          next_state = FPUWAIT;
      end
      FPUWB:    next_state = FETCH;
      FPUABORT: next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.FpuW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.FpuStart  = 1'b0;
    bus.FpuErr    = 1'b0;
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:   bus.ALUSrcB = 2'b01;
      MEMREAD:  bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: bus.ALUOp = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      ALUWB:    bus.RegW = 1'b1;
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      FPUISSUE: bus.FpuStart = 1'b1;
      FPUWB:    bus.FpuW     = 1'b1;
      FPUABORT: bus.FpuErr   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle control sequencer for the processor datapath, extended with an FPU issue/wait/writeback path. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the unconditional enables (NextPC, RegW, MemW, FpuW, Branch) that the condition-logic stage gates with CondEx. It also drives the datapath mux selects and the start/done handshake to the multicycle FPU.

## Interface
Parameters:
- FPU_TIMEOUT, 16: maximum cycles spent in FPUWAIT before abort; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 FPU
- Funct  in  6  instruction funct; Funct[5]=immediate, Funct[0]=load
- FpuDone  in  1  FPU result valid, single-cycle pulse
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select (0 PC, 1 ALU result)
- ALUSrcA  out  1  ALU A select
- ALUSrcB  out  2  ALU B select
- ResultSrc  out  2  result bus select
- ALUOp  out  1  1 = ALU decoder uses Funct, 0 = add
- NextPC  out  1  unconditional PC update
- RegW  out  1  register write request (pre-condition)
- MemW  out  1  memory write request (pre-condition)
- FpuW  out  1  FPU register write request (pre-condition)
- Branch  out  1  branch request (pre-condition)
- FpuStart  out  1  FPU operation start pulse
- FpuErr  out  1  FPU timeout abort indication

## Operation
- All outputs are a Moore decode of the registered state. There is no combinational path from inputs to outputs.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state is DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
    - Op 01 → MEMADR
    - Op 00 with Funct[5]=0 → EXECUTER
    - Op 00 with Funct[5]=1 → EXECUTEI
    - Op 10 → BRANCH
    - Op 11 → FPUISSUE
  - MEMADR: ALUSrcA=0, ALUSrcB=01. Next state is MEMREAD if Funct[0]=1, otherwise MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Next state is FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next state is FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next state is ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next state is ALUWB.
  - ALUWB: ResultSrc=00, RegW=1. Next state is FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Next state is FETCH.
  - FPUISSUE: FpuStart=1. Clear the wait counter. Next state is FPUWAIT.
  - FPUWAIT: Increment the counter each cycle.
    - FpuDone=1 → FPUWB.
    - Else, counter == FPU_TIMEOUT-1 → FPUABORT.
    - Else, stay in FPUWAIT.
  - FPUWB: ResultSrc=00, FpuW=1. Next state is FETCH.
  - FPUABORT: FpuErr=1. No register or FPU write. Next state is FETCH.
- Wait counter:
  - Width is $clog2(FPU_TIMEOUT+1).
  - It counts only in FPUWAIT and holds its value in all other states.
  - It never wraps, because the abort transition fires first.
- FpuDone is sampled only in FPUWAIT and ignored in every other state. A stray pulse causes no transition and no error.
- FpuDone=1 in the same cycle the counter reaches FPU_TIMEOUT-1: done wins, next state is FPUWB, FpuErr stays 0.
- Unused state encodings go to FETCH on the next edge.

## Timing
- Reset asserted (reset=0), applied immediately, asynchronous:
  - State = FETCH and counter = 0.
  - Outputs show the FETCH decode: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - All other outputs are 0.
- Reset deasserted: the first rising edge moves to DECODE.
- Cycles per instruction, counted from FETCH:
  - Data-processing: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - FPU: 4 + k, where k is the number of cycles spent in FPUWAIT, 1 ≤ k ≤ FPU_TIMEOUT. The FPUWB cycle is counted in the 4.
  - FPU abort: 4 + FPU_TIMEOUT.
- FpuStart is high for exactly one cycle per FPU instruction.
- The earliest FpuDone that is accepted arrives in the first FPUWAIT cycle, one cycle after FpuStart.
- Reset asserted in any state, including mid-FPUWAIT, returns the block to FETCH with no FpuW, FpuErr or MemW pulse.

## Test plan
- Reset release, Op=00, Funct=000000: state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH.
  - RegW=1 only in cycle 4.
  - ALUOp=1 only in cycle 3.
  - IRWrite=1 and NextPC=1 in cycle 1.
- Op=01, Funct[0]=1, then Op=01, Funct[0]=0:
  - Load: RegW=1 only in cycle 5, with ResultSrc=01 in that cycle.
  - Store: MemW=1 only in cycle 4, with AdrSrc=1 in that cycle.
  - No RegW during the store.
- Op=10: Branch=1 in cycle 3 with ALUSrcB=01, then FETCH in cycle 4.
- Op=11 with FPU_TIMEOUT=16, FpuDone pulsed on the 3rd FPUWAIT cycle:
  - FpuStart=1 in cycle 3 only.
  - FpuW=1 in cycle 7 only.
  - FpuErr stays 0.
- Op=11 with FpuDone never asserted: FPUABORT is reached after 16 FPUWAIT cycles, FpuErr=1 for one cycle, FpuW never asserted, then FETCH.
  - Repeat with FpuDone on the 16th wait cycle: required result is FPUWB, FpuErr=0.
- Boundary and reset cases:
  - FpuDone pulsed in FETCH or EXECUTER: no state deviation.
  - reset=0 mid-FPUWAIT (counter=7): outputs show the FETCH decode immediately and the counter reads 0.
